mtc_sl_tx_buffer: RTL and testbench

MTC_SL_TX_BUFFER -- requirements
Module: mtc_sl_tx_buffer

---
 rtl/l0mdt_buses_constants.sv | 16 +
 rtl/mtc_sl_tx_buffer_pkg.sv | 19 +
 rtl/mtc_tx_fifo.sv | 100 ++++++++++
 rtl/mtc_sl_tx_buffer.sv | 55 +++++
 tb/tb_mtc_sl_tx_buffer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/l0mdt_buses_constants.sv
// ---------------------------------------------------------------------------
// l0mdt_buses_constants
// Shared L0MDT bus layout constants (MTC-to-SL word). This is the common
// package consumed across the trigger-path blocks; local blocks import it
// rather than redefining bus widths or field positions.
// ---------------------------------------------------------------------------
package l0mdt_buses_constants;

  // MTC-to-SL word: [31] valid flag, [30:0] payload.
  localparam int MTC2SL_LEN       = 32;
  localparam int MTC2SL_VALID_MSB = 31;
  localparam int MTC2SL_VALID_LSB = 31;
  localparam int MTC2SL_DATA_MSB  = 30;
  localparam int MTC2SL_DATA_LSB  = 0;

endpackage : l0mdt_buses_constants

// File: rtl/mtc_sl_tx_buffer_pkg.sv
// ---------------------------------------------------------------------------
// mtc_sl_tx_buffer_pkg
// Block-local helpers for the MTC-to-SL transmit buffer. Bus constants come
// from l0mdt_buses_constants; only FIFO sizing helpers live here.
// ---------------------------------------------------------------------------
package mtc_sl_tx_buffer_pkg;

  import l0mdt_buses_constants::*;

  localparam int MTC_FIFO_MIN_DEPTH = 2;
  localparam int MTC_FIFO_MAX_DEPTH = 16;

  // Occupancy needs one extra bit over the pointer so that "full"
  // (count == depth) is distinguishable from "empty".
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : mtc_sl_tx_buffer_pkg

// File: rtl/mtc_tx_fifo.sv
// ---------------------------------------------------------------------------
// mtc_tx_fifo
// One SL link transmit FIFO: storage, read/write pointers, occupancy count
// and a saturating overflow counter. First-word-fall-through: the head word
// is presented combinationally from the registered read pointer and count.
//
// Ports
//   clock     in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   srst      in   synchronous active-high reset (overrides read/write)
//   wr_word   in   [WIDTH]   MTC word, MSB = valid/write request
//   rd_ready  in   transmitter accepts the head word this cycle
//   data      out  [WIDTH]   head word, zero when empty
//   valid     out  FIFO not empty
//   full      out  FIFO holds DEPTH entries
//   ovf_cnt   out  [OVF_CNT_WIDTH] saturating dropped-word count
// ---------------------------------------------------------------------------
module mtc_tx_fifo
  import mtc_sl_tx_buffer_pkg::*;
#(
  parameter int WIDTH         = l0mdt_buses_constants::MTC2SL_LEN,
  parameter int DEPTH         = 4,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     srst,
  input  logic [WIDTH-1:0]         wr_word,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         data,
  output logic                     valid,
  output logic                     full,
  output logic [OVF_CNT_WIDTH-1:0] ovf_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fifo_cnt_width(DEPTH);

  logic [WIDTH-1:0]         mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_reg;
  logic [PTR_W-1:0]         rd_ptr_reg;
  logic [CNT_W-1:0]         count_reg;
  logic [CNT_W-1:0]         count_next;
  logic [OVF_CNT_WIDTH-1:0] ovf_cnt_reg;

  logic wr_req;
  logic rd_en;
  logic wr_en;
  logic drop;

  assign valid  = (count_reg != '0);
  assign full   = (count_reg == CNT_W'(DEPTH));
  assign wr_req = wr_word[WIDTH-1];
  assign rd_en  = valid & rd_ready;
  // A read in the same cycle frees the head slot, so a full FIFO can still
  // accept; the new word lands in the slot being vacated.
  assign wr_en  = wr_req & (~full | rd_en);
  assign drop   = wr_req & full & ~rd_en;

  assign data    = valid ? mem[rd_ptr_reg] : '0;
  assign ovf_cnt = ovf_cnt_reg;

  always_comb begin
    count_next = count_reg;
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage is not reset: data is masked to zero while empty.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_word;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      ovf_cnt_reg <= '0;
    end else if (srst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      ovf_cnt_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      if (drop && (ovf_cnt_reg != '1)) begin
        ovf_cnt_reg <= ovf_cnt_reg + OVF_CNT_WIDTH'(1);
      end
    end
  end

endmodule : mtc_tx_fifo

// File: rtl/mtc_sl_tx_buffer.sv
// ---------------------------------------------------------------------------
// mtc_sl_tx_buffer
// Per-link transmit buffering between the MTC builder and the SL link
// transmitters. Each link gets an independent mtc_tx_fifo; this level only
// fans the link arrays out to those instances.
//
// Ports
//   clock       in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   srst        in   synchronous active-high reset
//   mtc_in      in   [N_LINKS][MTC_WIDTH] MTC words, MSB = valid
//   link_ready  in   [N_LINKS] transmitter accepts head word
//   link_data   out  [N_LINKS][MTC_WIDTH] head word, zero when empty
//   link_valid  out  [N_LINKS] FIFO not empty
//   fifo_full   out  [N_LINKS] FIFO full
//   ovf_cnt     out  [N_LINKS][OVF_CNT_WIDTH] saturating drop counters
// ---------------------------------------------------------------------------
module mtc_sl_tx_buffer
  import mtc_sl_tx_buffer_pkg::*;
#(
  parameter int MTC_WIDTH     = l0mdt_buses_constants::MTC2SL_LEN,
  parameter int N_LINKS       = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic                                   clock,
  input  logic                                   rst,
  input  logic                                   srst,
  input  logic [N_LINKS-1:0][MTC_WIDTH-1:0]      mtc_in,
  input  logic [N_LINKS-1:0]                     link_ready,
  output logic [N_LINKS-1:0][MTC_WIDTH-1:0]      link_data,
  output logic [N_LINKS-1:0]                     link_valid,
  output logic [N_LINKS-1:0]                     fifo_full,
  output logic [N_LINKS-1:0][OVF_CNT_WIDTH-1:0]  ovf_cnt
);

  for (genvar gi = 0; gi < N_LINKS; gi++) begin : g_link
    mtc_tx_fifo #(
      .WIDTH         (MTC_WIDTH),
      .DEPTH         (FIFO_DEPTH),
      .OVF_CNT_WIDTH (OVF_CNT_WIDTH)
    ) u_fifo (
      .clock    (clock),
      .rst      (rst),
      .srst     (srst),
      .wr_word  (mtc_in[gi]),
      .rd_ready (link_ready[gi]),
      .data     (link_data[gi]),
      .valid    (link_valid[gi]),
      .full     (fifo_full[gi]),
      .ovf_cnt  (ovf_cnt[gi])
    );
  end

endmodule : mtc_sl_tx_buffer

// File: tb/tb_mtc_sl_tx_buffer.sv
module tb_mtc_sl_tx_buffer;
  import l0mdt_buses_constants::*;

  localparam int W       = MTC2SL_LEN;
  localparam int N       = 3;
  localparam int D       = 4;
  localparam int OW      = 2;
  localparam int OVF_MAX = (1 << OW) - 1;

  typedef logic [N-1:0][W-1:0] bus_t;

  logic             clock = 1'b0;
  logic             rst   = 1'b0;
  logic             srst  = 1'b0;
  bus_t             mtc_in = '0;
  logic [N-1:0]     link_ready = '0;
  bus_t             link_data;
  logic [N-1:0]     link_valid;
  logic [N-1:0]     fifo_full;
  logic [N-1:0][OW-1:0] ovf_cnt;

  mtc_sl_tx_buffer #(
    .MTC_WIDTH     (W),
    .N_LINKS       (N),
    .FIFO_DEPTH    (D),
    .OVF_CNT_WIDTH (OW)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .srst       (srst),
    .mtc_in     (mtc_in),
    .link_ready (link_ready),
    .link_data  (link_data),
    .link_valid (link_valid),
    .fifo_full  (fifo_full),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: one queue of accepted words per link plus drop counters.
  logic [W-1:0] q [N][$];
  int           ovf [N];
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input int link, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s link%0d observed=%h expected=%h", tag, link, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      ovf[i] = 0;
    end
  endfunction

  function automatic void model_step(input bus_t din, input logic [N-1:0] rdy, input logic s);
    if (s) begin
      model_clear();
      return;
    end
    for (int i = 0; i < N; i++) begin
      bit rd, want;
      rd   = (q[i].size() > 0) && rdy[i];
      want = din[i][W-1];
      if (rd) void'(q[i].pop_front());
      if (want) begin
        if (q[i].size() < D) q[i].push_back(din[i]);
        else if (ovf[i] < OVF_MAX) ovf[i]++;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] exp_data;
      exp_data = (q[i].size() > 0) ? q[i][0] : '0;
      chk({tag, "_valid"}, i, W'(link_valid[i]), W'(q[i].size() > 0));
      chk({tag, "_data"},  i, link_data[i], exp_data);
      chk({tag, "_full"},  i, W'(fifo_full[i]), W'(q[i].size() == D));
      chk({tag, "_ovf"},   i, W'(ovf_cnt[i]), W'(ovf[i]));
    end
  endtask

  task automatic step(input bus_t din, input logic [N-1:0] rdy, input logic s, input string tag);
    mtc_in     = din;
    link_ready = rdy;
    srst       = s;
    model_step(din, rdy, s);
    @(posedge clock);
    #1;
    mtc_in     = '0;
    link_ready = '0;
    srst       = 1'b0;
    $display("t=%0t %s in=%h rdy=%b srst=%b valid=%b full=%b", $time, tag, din, rdy, s, link_valid, fifo_full);
    check_all(tag);
  endtask

  function automatic bus_t one(input int link, input logic [W-1:0] w);
    bus_t b;
    b = '0;
    b[link] = w;
    return b;
  endfunction

  function automatic logic [W-1:0] vword();
    logic [W-1:0] r;
    r = W'($urandom);
    r[W-1] = 1'b1;
    return r;
  endfunction

  initial begin
    logic [W-1:0] w [6];
    logic [W-1:0] nw;
    bus_t         din;
    model_clear();

    // Asynchronous reset with no clock edge involved.
    #1 rst = 1'b1;
    #1 check_all("reset");
    #1 rst = 1'b0;

    // Single word, 1-cycle latency then popped.
    step(one(0, 32'h800000A5), 3'b111, 1'b0, "single_w");
    chk("single_head", 0, link_data[0], 32'h800000A5);
    step('0, 3'b111, 1'b0, "single_pop");
    chk("single_gone", 0, W'(link_valid[0]), W'(0));

    // Fill and overflow: 6 words, ready low.
    for (int k = 0; k < 6; k++) begin
      w[k] = vword();
      step(one(0, w[k]), 3'b000, 1'b0, "fill");
      if (k == 3) chk("full_after_4", 0, W'(fifo_full[0]), W'(1));
    end
    chk("ovf_two", 0, W'(ovf_cnt[0]), W'(2));
    for (int k = 0; k < 4; k++) begin
      chk("drain_order", 0, link_data[0], w[k]);
      step('0, 3'b001, 1'b0, "drain");
    end
    chk("drained", 0, W'(link_valid[0]), W'(0));

    // Full with simultaneous read and write.
    for (int k = 0; k < 4; k++) begin
      w[k] = vword();
      step(one(0, w[k]), 3'b000, 1'b0, "refill");
    end
    nw = vword();
    step(one(0, nw), 3'b001, 1'b0, "full_rw");
    chk("full_rw_full", 0, W'(fifo_full[0]), W'(1));
    chk("full_rw_ovf", 0, W'(ovf_cnt[0]), W'(2));
    for (int k = 1; k < 4; k++) begin
      chk("full_rw_order", 0, link_data[0], w[k]);
      step('0, 3'b001, 1'b0, "full_rw_drain");
    end
    chk("full_rw_new4th", 0, link_data[0], nw);
    step('0, 3'b001, 1'b0, "full_rw_last");

    // Invalid words on link 1 while link 2 streams.
    for (int k = 0; k < 8; k++) begin
      din = '0;
      din[1] = W'($urandom) & {1'b0, {(W-1){1'b1}}};
      nw = vword();
      din[2] = nw;
      step(din, 3'b110, 1'b0, "indep");
      chk("indep_l1_idle", 1, W'(link_valid[1]), W'(0));
      chk("indep_l2_data", 2, link_data[2], nw);
    end
    step('0, 3'b100, 1'b0, "indep_end");

    // Saturation of the 2-bit drop counter on link 2.
    for (int k = 0; k < 9; k++) step(one(2, vword()), 3'b000, 1'b0, "sat");
    chk("sat_three", 2, W'(ovf_cnt[2]), W'(3));
    for (int k = 0; k < 4; k++) step('0, 3'b100, 1'b0, "sat_drain");

    // Asynchronous reset with 3 words queued on link 0.
    for (int k = 0; k < 3; k++) step(one(0, vword()), 3'b000, 1'b0, "pre_rst");
    #1 rst = 1'b1;
    #1 model_clear();
    check_all("rst_mid");
    chk("rst_mid_ovf2", 2, W'(ovf_cnt[2]), W'(0));
    #1 rst = 1'b0;
    nw = vword();
    step(one(0, nw), 3'b000, 1'b0, "post_rst_w");
    chk("post_rst_accept", 0, link_data[0], nw);

    // Synchronous reset with a concurrent write: both cleared.
    for (int k = 0; k < 2; k++) step(one(0, vword()), 3'b000, 1'b0, "pre_srst");
    step(one(0, vword()), 3'b001, 1'b1, "srst_w");
    chk("srst_drop", 0, W'(link_valid[0]), W'(0));
    nw = vword();
    step(one(0, nw), 3'b000, 1'b0, "post_srst_w");
    chk("post_srst_accept", 0, link_data[0], nw);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      logic [N-1:0] rdy;
      for (int i = 0; i < N; i++) begin
        din[i] = W'($urandom);
        din[i][W-1] = ($urandom_range(0, 9) < 6);
        rdy[i] = ($urandom_range(0, 9) < 4);
      end
      step(din, rdy, ($urandom_range(0, 99) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mtc_sl_tx_buffer
